// File: rtl/pwm_capture_pkg.sv
// Shared constants for pwm_capture: register map, STATUS/CTRL bit positions
// and FSM state encoding.
package pwm_capture_pkg;

  localparam int unsigned REG_HIGH   = 0;
  localparam int unsigned REG_PERIOD = 1;
  localparam int unsigned REG_STATUS = 2;
  localparam int unsigned REG_CTRL   = 3;

  localparam int STATUS_VALID = 0;
  localparam int STATUS_OVF   = 1;
  localparam int CTRL_EN      = 0;

  localparam logic [1:0] ST_DISABLED  = 2'd0;
  localparam logic [1:0] ST_ARM       = 2'd1;
  localparam logic [1:0] ST_MEAS_HIGH = 2'd2;
  localparam logic [1:0] ST_MEAS_LOW  = 2'd3;

endpackage

// File: rtl/pwm_capture_sync.sv
// PIN conditioning: 2-flop synchronizer, optional glitch filter
// (PWM_CAPTURE_FILTER_EN) and a 1-flop edge detector producing rise/fall pulses.
module pwm_capture_sync (
  input  logic clk,
  input  logic rst_n,
  input  logic pin,
  output logic level,
  output logic rise,
  output logic fall
);

  logic sync_a;
  logic sync_b;
  logic filt;
  logic prev;

  always_ff @(posedge clk) begin
    if (!rst_n) begin
      sync_a <= 1'b0;
      sync_b <= 1'b0;
    end else begin
      sync_a <= pin;
      sync_b <= sync_a;
    end
  end

`ifdef PWM_CAPTURE_FILTER_EN
  logic hist_a;
  logic hist_b;
  logic held;

  // The level only follows the synchronizer once three samples in a row agree.
  always_comb begin
    filt = held;
    if ((sync_b == hist_a) && (hist_a == hist_b)) filt = sync_b;
  end

  always_ff @(posedge clk) begin
    if (!rst_n) begin
      hist_a <= 1'b0;
      hist_b <= 1'b0;
      held   <= 1'b0;
    end else begin
      hist_a <= sync_b;
      hist_b <= hist_a;
      held   <= filt;
    end
  end
`else
  always_comb filt = sync_b;
`endif

  always_ff @(posedge clk) begin
    if (!rst_n) prev <= 1'b0;
    else        prev <= filt;
  end

  assign level = filt;
  assign rise  = filt & ~prev;
  assign fall  = ~filt & prev;

endmodule

// File: rtl/pwm_capture.sv
// PWM high-time / period capture with a small register interface.
// Define PWM_CAPTURE_FILTER_EN to add a 3-sample glitch filter on PIN.
module pwm_capture
  import pwm_capture_pkg::*;
#(
  parameter int BITS         = 16,
  parameter int ADDRESS_BITS = 8,
  parameter int CLK_FREQ     = 12000000
) (
  input  logic                    CLK,
  input  logic                    RSTb,
  input  logic [ADDRESS_BITS-1:0] ADDRESS,
  input  logic [BITS-1:0]         DATA_IN,
  output logic [BITS-1:0]         DATA_OUT,
  input  logic                    WRb,
  input  logic                    PIN,
  output logic [1:0]              fsm_state
);

  localparam logic [BITS-1:0] CNT_MAX       = '1;
  localparam logic [31:0]     CLK_FREQ_BITS = CLK_FREQ;

  logic [1:0]      state;
  logic [BITS-1:0] cnt;
  logic [BITS-1:0] cnt_next;
  logic [BITS-1:0] high_tmp;
  logic [BITS-1:0] high_q;
  logic [BITS-1:0] period_q;
  logic            valid;
  logic            ovf;
  logic            en;
  logic            level;
  logic            rise;
  logic            fall;
  logic            wr_status;
  logic            wr_ctrl;
  logic            capture;
  logic            overflow;
  logic            unused_bits;

  pwm_capture_sync u_sync (
    .clk   (CLK),
    .rst_n (RSTb),
    .pin   (PIN),
    .level (level),
    .rise  (rise),
    .fall  (fall)
  );

  assign wr_status = !WRb && (ADDRESS == ADDRESS_BITS'(REG_STATUS));
  assign wr_ctrl   = !WRb && (ADDRESS == ADDRESS_BITS'(REG_CTRL));

  // Counter saturates so a terminating edge at all-ones cannot wrap it.
  assign cnt_next = (cnt == CNT_MAX) ? cnt : cnt + 1'b1;

  assign capture  = en && (state == ST_MEAS_LOW) && rise;
  assign overflow = en && (cnt == CNT_MAX) &&
                    (((state == ST_MEAS_HIGH) && !fall) ||
                     ((state == ST_MEAS_LOW) && !rise));

  always_ff @(posedge CLK) begin
    if (!RSTb) begin
      state    <= ST_DISABLED;
      cnt      <= '0;
      high_tmp <= '0;
      high_q   <= '0;
      period_q <= '0;
    end else if (!en) begin
      state <= ST_DISABLED;
    end else if (overflow) begin
      state <= ST_ARM;
    end else begin
      case (state)
        ST_DISABLED: state <= ST_ARM;
        ST_ARM: begin
          if (rise) begin
            state <= ST_MEAS_HIGH;
            cnt   <= BITS'(1);
          end
        end
        ST_MEAS_HIGH: begin
          cnt <= cnt_next;
          if (fall) begin
            high_tmp <= cnt;
            state    <= ST_MEAS_LOW;
          end
        end
        ST_MEAS_LOW: begin
          if (capture) begin
            high_q   <= high_tmp;
            period_q <= cnt;
            cnt      <= BITS'(1);
            state    <= ST_MEAS_HIGH;
          end else begin
            cnt <= cnt_next;
          end
        end
        default: state <= ST_DISABLED;
      endcase
    end
  end

  // Hardware sets take priority over a write-one-to-clear in the same cycle.
  always_ff @(posedge CLK) begin
    if (!RSTb) begin
      valid <= 1'b0;
      ovf   <= 1'b0;
      en    <= 1'b0;
    end else begin
      if (capture)                                valid <= 1'b1;
      else if (wr_status && DATA_IN[STATUS_VALID]) valid <= 1'b0;
      if (overflow)                               ovf <= 1'b1;
      else if (wr_status && DATA_IN[STATUS_OVF])   ovf <= 1'b0;
      if (wr_ctrl) en <= DATA_IN[CTRL_EN];
    end
  end

  always_comb begin
    DATA_OUT = '0;
    if (RSTb) begin
      case (ADDRESS)
        ADDRESS_BITS'(REG_HIGH):   DATA_OUT = high_q;
        ADDRESS_BITS'(REG_PERIOD): DATA_OUT = period_q;
        ADDRESS_BITS'(REG_STATUS): begin
          DATA_OUT[STATUS_VALID] = valid;
          DATA_OUT[STATUS_OVF]   = ovf;
        end
        ADDRESS_BITS'(REG_CTRL):   DATA_OUT[CTRL_EN] = en;
        default:                   DATA_OUT = '0;
      endcase
    end
  end

  assign fsm_state   = state;
  assign unused_bits = ^{DATA_IN[BITS-1:2], level, CLK_FREQ_BITS};

endmodule

// File: tb/tb_pwm_capture.sv
// Bench for pwm_capture: register table, directed PWM sequences and random
// periods checked against a (high, period) expectation queue.
`timescale 1ns/1ps
module tb_pwm_capture;
  import pwm_capture_pkg::*;

  localparam int BITS = 16;
  localparam int AW   = 8;
`ifdef PWM_CAPTURE_FILTER_EN
  localparam int LAT = 5;
`else
  localparam int LAT = 3;
`endif

  logic            CLK = 1'b0;
  logic            RSTb;
  logic [AW-1:0]   ADDRESS;
  logic [BITS-1:0] DATA_IN;
  logic [BITS-1:0] DATA_OUT;
  logic            WRb;
  logic            PIN;
  logic [1:0]      fsm_state;

  int n_checks = 0;
  int n_errors = 0;

  // Model: every PWM period driven becomes an expected {high, period} record
  // once the next rising edge closes it.
  logic [2*BITS-1:0] exp_q[$];
  logic [2*BITS-1:0] prev_rec;
  bit                have_prev = 0;
  logic [BITS-1:0]   last_high = '0;
  logic [BITS-1:0]   last_period = '0;

  typedef struct {
    logic [AW-1:0]   addr;
    logic            wr;
    logic [BITS-1:0] data;
    logic [BITS-1:0] exp;
  } vec_t;
  vec_t vecs[13];

  pwm_capture #(.BITS(BITS), .ADDRESS_BITS(AW), .CLK_FREQ(12000000)) dut (
    .CLK       (CLK),
    .RSTb      (RSTb),
    .ADDRESS   (ADDRESS),
    .DATA_IN   (DATA_IN),
    .DATA_OUT  (DATA_OUT),
    .WRb       (WRb),
    .PIN       (PIN),
    .fsm_state (fsm_state)
  );

  always #5 CLK = ~CLK;

  task automatic tick();
    @(posedge CLK);
    #1;
  endtask

  task automatic check(input string name, input logic [BITS-1:0] act, input logic [BITS-1:0] exp);
    n_checks++;
    if (act !== exp) begin
      n_errors++;
      $display("FAIL %s: got %h, expected %h at %0t", name, act, exp, $time);
    end
  endtask

  task automatic read_reg(input logic [AW-1:0] a, output logic [BITS-1:0] d);
    ADDRESS = a;
    #1;
    d = DATA_OUT;
  endtask

  task automatic write_reg(input logic [AW-1:0] a, input logic [BITS-1:0] d);
    ADDRESS = a;
    DATA_IN = d;
    WRb     = 1'b0;
    tick();
    WRb     = 1'b1;
  endtask

  task automatic check_capture();
    logic [2*BITS-1:0] e;
    logic [BITS-1:0]   d;
    e           = exp_q.pop_front();
    last_high   = e[2*BITS-1:BITS];
    last_period = e[BITS-1:0];
    read_reg(8'h00, d);
    check("high", d, last_high);
    read_reg(8'h01, d);
    check("period", d, last_period);
    read_reg(8'h02, d);
    check("valid", d & 16'h0001, 16'h0001);
  endtask

  // One PWM period starting with a rising edge; optionally a STATUS clear
  // whose write edge is tick clr_at of the period.
  task automatic run_period(input int n, input int p, input int clr_at, input logic clr_exp);
    logic [BITS-1:0] d;
    if (have_prev) exp_q.push_back(prev_rec);
    PIN = 1'b1;
    for (int i = 0; i < p; i++) begin
      if (i == n) PIN = 1'b0;
      if (i == LAT + 3 && exp_q.size() > 0) check_capture();
      if (i == clr_at) begin
        ADDRESS = 8'h02;
        DATA_IN = 16'h0001;
        WRb     = 1'b0;
      end
      tick();
      WRb = 1'b1;
      if (i == clr_at) begin
        read_reg(8'h02, d);
        check("valid_after_clear", d & 16'h0001, {15'b0, clr_exp});
      end
    end
    prev_rec  = {BITS'(n), BITS'(p)};
    have_prev = 1;
  endtask

  task automatic check_all_zero(input string name);
    logic [BITS-1:0] d;
    for (int a = 0; a < 4; a++) begin
      read_reg(AW'(a), d);
      check($sformatf("%s_reg%0d", name, a), d, '0);
    end
  endtask

  initial begin
    logic [BITS-1:0] d;
    int n;
    int p;

    vecs[0]  = '{8'h00, 1'b0, 16'h0000, 16'h0000};
    vecs[1]  = '{8'h01, 1'b0, 16'h0000, 16'h0000};
    vecs[2]  = '{8'h02, 1'b0, 16'h0000, 16'h0000};
    vecs[3]  = '{8'h03, 1'b0, 16'h0000, 16'h0000};
    vecs[4]  = '{8'h04, 1'b0, 16'h0000, 16'h0000};
    vecs[5]  = '{8'h03, 1'b1, 16'hFFFF, 16'h0001};
    vecs[6]  = '{8'h02, 1'b1, 16'hFFFF, 16'h0000};
    vecs[7]  = '{8'h00, 1'b1, 16'h1234, 16'h0000};
    vecs[8]  = '{8'h01, 1'b1, 16'hBEEF, 16'h0000};
    vecs[9]  = '{8'h80, 1'b1, 16'h5555, 16'h0000};
    vecs[10] = '{8'h03, 1'b1, 16'hFFFE, 16'h0000};
    vecs[11] = '{8'hFF, 1'b0, 16'h0000, 16'h0000};
    vecs[12] = '{8'h03, 1'b1, 16'h0000, 16'h0000};

    RSTb    = 1'b0;
    WRb     = 1'b1;
    PIN     = 1'b0;
    ADDRESS = '0;
    DATA_IN = '0;
    repeat (3) tick();
    check_all_zero("in_reset");
    check("reset_state", {14'b0, fsm_state}, {14'b0, ST_DISABLED});
    RSTb = 1'b1;
    tick();

    for (int i = 0; i < 13; i++) begin
      if (vecs[i].wr) write_reg(vecs[i].addr, vecs[i].data);
      read_reg(vecs[i].addr, d);
      check($sformatf("vec%0d", i), d, vecs[i].exp);
    end

    // Nominal 300/1000 waveform, then clear VALID and watch it come back.
    write_reg(8'h03, 16'h0001);
    repeat (2) tick();
    check("armed_state", {14'b0, fsm_state}, {14'b0, ST_ARM});
    have_prev = 0;
    for (int k = 0; k < 4; k++) run_period(300, 1000, -1, 1'b0);
    run_period(300, 1000, 400, 1'b0);
    run_period(300, 1000, -1, 1'b0);

    // Clear collides with the capture edge: the set must win.
    run_period(200, 500, 300, 1'b0);
    run_period(200, 500, LAT - 1, 1'b1);

    for (int k = 0; k < 8; k++) begin
      p = $urandom_range(160, 40);
      n = $urandom_range(p - 12, 12);
      run_period(n, p, -1, 1'b0);
    end

    // Long high: counter saturates, OVF sets, captures stay put.
    if (have_prev) exp_q.push_back(prev_rec);
    have_prev = 0;
    PIN = 1'b1;
    for (int i = 0; i < 70000; i++) begin
      if (i == LAT + 3) check_capture();
      tick();
    end
    read_reg(8'h00, d);
    check("ovf_high", d, last_high);
    read_reg(8'h01, d);
    check("ovf_period", d, last_period);
    read_reg(8'h02, d);
    check("ovf_status", d, 16'h0003);
    check("ovf_state", {14'b0, fsm_state}, {14'b0, ST_ARM});
    PIN = 1'b0;
    repeat (20) tick();

    // Disable mid-measurement, then reset.
    run_period(50, 120, -1, 1'b0);
    exp_q.push_back(prev_rec);
    have_prev = 0;
    PIN = 1'b1;
    for (int i = 0; i < LAT + 23; i++) begin
      if (i == LAT + 3) check_capture();
      tick();
    end
    write_reg(8'h03, 16'h0000);
    repeat (2) tick();
    check("dis_state", {14'b0, fsm_state}, {14'b0, ST_DISABLED});
    PIN = 1'b0;
    repeat (60) tick();
    read_reg(8'h00, d);
    check("dis_high", d, last_high);
    read_reg(8'h01, d);
    check("dis_period", d, last_period);
    read_reg(8'h02, d);
    check("dis_status", d, 16'h0003);
    RSTb = 1'b0;
    repeat (2) tick();
    check_all_zero("rst_held");
    RSTb = 1'b1;
    tick();
    check_all_zero("after_rst");
    check("after_rst_state", {14'b0, fsm_state}, {14'b0, ST_DISABLED});

    // 2-cycle low glitch inside a 100-cycle high, period 500.
    write_reg(8'h03, 16'h0001);
    repeat (3) tick();
    PIN = 1'b1;
    repeat (49) tick();
    PIN = 1'b0;
    repeat (2) tick();
    PIN = 1'b1;
    repeat (LAT + 3) tick();
    read_reg(8'h00, d);
`ifdef PWM_CAPTURE_FILTER_EN
    check("glitch_mid_high", d, 16'd0);
`else
    check("glitch_mid_high", d, 16'd49);
`endif
    read_reg(8'h01, d);
`ifdef PWM_CAPTURE_FILTER_EN
    check("glitch_mid_period", d, 16'd0);
`else
    check("glitch_mid_period", d, 16'd51);
`endif
    repeat (49 - (LAT + 3)) tick();
    PIN = 1'b0;
    repeat (400) tick();
    PIN = 1'b1;
    repeat (LAT + 3) tick();
    read_reg(8'h00, d);
`ifdef PWM_CAPTURE_FILTER_EN
    check("glitch_high", d, 16'd100);
`else
    check("glitch_high", d, 16'd49);
`endif
    read_reg(8'h01, d);
`ifdef PWM_CAPTURE_FILTER_EN
    check("glitch_period", d, 16'd500);
`else
    check("glitch_period", d, 16'd449);
`endif

    $display("Simulation finished: %0d checks, %0d errors", n_checks, n_errors);
    $finish;
  end

endmodule

// File: doc/pwm_capture.md
PWM_CAPTURE -- requirements
Module: pwm_capture

Interface
REQ-001 SHALL have parameter BITS, default 16: width of the data bus, the counters and the capture registers.
REQ-002 SHALL have parameter ADDRESS_BITS, default 8: width of the register address.
REQ-003 SHALL have parameter CLK_FREQ, default 12000000: informational clock frequency in Hz; no logic depends on it.
REQ-004 SHALL have port CLK, input, 1 bit: the single clock; all state changes on its rising edge.
REQ-005 SHALL have port RSTb, input, 1 bit: reset, synchronous and active-low.
REQ-006 SHALL have port ADDRESS, input, ADDRESS_BITS: register select.
REQ-007 SHALL have port DATA_IN, input, BITS: write data.
REQ-008 SHALL have port DATA_OUT, output, BITS: read data.
REQ-009 SHALL have port WRb, input, 1 bit: active-low write strobe, sampled every CLK.
REQ-010 SHALL have port PIN, input, 1 bit: asynchronous PWM signal to be measured.

Function
REQ-011 SHALL decode register 0x00 HIGH (read-only): last captured high time, in CLK cycles.
REQ-012 SHALL decode register 0x01 PERIOD (read-only): last captured rise-to-rise period, in CLK cycles.
REQ-013 SHALL decode register 0x02 STATUS: bit0 VALID, bit1 OVF; a write with a 1 in a bit clears that bit; other bits read 0.
REQ-014 SHALL decode register 0x03 CTRL (read/write): bit0 EN; other bits read 0.
REQ-015 SHALL drive DATA_OUT combinationally from ADDRESS every cycle, independent of WRb; unmapped addresses return 0.
REQ-016 SHALL pass PIN through a 2-flop synchronizer and then a 1-flop edge detector; a PIN transition is seen as a rise or fall pulse 3 CLK after it occurs.
REQ-017 SHALL implement the FSM states DISABLED, ARM, MEAS_HIGH and MEAS_LOW.
REQ-018 SHALL move DISABLED->ARM when EN=1, and from any state ->DISABLED when EN=0; captured values and flags are kept on disable.
REQ-019 SHALL move ARM->MEAS_HIGH on a rise pulse and load cnt with 1 on the following edge.
REQ-020 SHALL increment cnt by 1 per cycle while in MEAS_HIGH or MEAS_LOW.
REQ-021 SHALL, on a fall pulse in MEAS_HIGH, store cnt in an internal high_tmp and move to MEAS_LOW.
REQ-022 SHALL, on a rise pulse in MEAS_LOW, load HIGH from high_tmp and PERIOD from cnt, set VALID, load cnt with 1, and move to MEAS_HIGH; measurement is back-to-back.
REQ-023 SHALL meet this result rule: an input high for N cycles with period P reports HIGH=N and PERIOD=P.
REQ-024 SHALL, when cnt equals all-ones while in MEAS_HIGH or MEAS_LOW with no terminating edge, set OVF, move to ARM and leave HIGH and PERIOD unchanged; cnt never wraps.
REQ-025 SHALL let a hardware set of VALID or OVF win over a clear written in the same cycle.
REQ-026 SHALL ignore a write to a read-only register.

Reset
REQ-027 SHALL, while RSTb=0 at a CLK edge, clear HIGH, PERIOD, high_tmp, cnt, VALID, OVF and EN, set the synchronizer flops to 0, and enter DISABLED.
REQ-028 SHALL drive DATA_OUT to 0 while in reset for any mapped address; a measurement in progress is discarded.

Configuration
REQ-029 SHALL, with PWM_CAPTURE_FILTER_EN defined, insert a glitch filter after the synchronizer: the filtered level changes only after 3 consecutive equal samples, adding 2 cycles of latency, so edges are seen 5 CLK after PIN changes; pulses shorter than 3 cycles are dropped.
REQ-030 SHALL, without PWM_CAPTURE_FILTER_EN, pass the synchronizer output straight to the edge detector.

Structure
REQ-031 SHALL define the register address constants, the STATUS/CTRL bit positions and the FSM state encoding in shared package pwm_capture_pkg.
REQ-032 SHALL put the synchronizer, the optional filter and the edge detector in one sub-module pwm_capture_sync; it outputs the level, a rise pulse and a fall pulse.

Verification
REQ-033 SHALL cover: EN=1, PIN with 300 cycles high and 1000-cycle period, 3 periods -> HIGH=300, PERIOD=1000, VALID=1.
REQ-034 SHALL cover: write 0x02 with 0x0001 -> VALID=0; the next period sets VALID=1 again.
REQ-035 SHALL cover: PIN held high for 70000 cycles with BITS=16 -> OVF=1, HIGH and PERIOD unchanged, FSM returns to ARM.
REQ-036 SHALL cover: clear written to STATUS in the same cycle VALID is set -> VALID reads 1.
REQ-037 SHALL cover: EN=0 mid-measurement, then RSTb=0 -> captured values are held while disabled; all registers read 0 after reset.
REQ-038 SHALL cover: with the filter built in, a 2-cycle glitch inside a 100-cycle high -> HIGH=100; without the filter the glitch splits the measurement.
